// File: rtl/sram_ctrl_initiator.sv
// rtl/sram_ctrl_initiator.sv - valid/ready initiator for a single-port OpenRAM SRAM macro (optional SRAM_CTRL_INIT_EN zero-fill sweep)
module sram_ctrl_initiator #(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 7,
   parameter int READ_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic                  sram_oeb,
   inout  wire  [DATA_WIDTH-1:0] sram_data
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WRITE    = 3'd1;
   localparam logic [2:0] S_RD_ISSUE = 3'd2;
   localparam logic [2:0] S_RD_WAIT  = 3'd3;
   localparam logic [2:0] S_RESP     = 3'd4;
   localparam logic [2:0] S_INIT     = 3'd5;

   // Counter wide enough to count READ_LAT-1 wait edges (at least one bit).
   localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(READ_LAT - 1);

`ifdef SRAM_CTRL_INIT_EN
   localparam logic [2:0] S_RESET = S_INIT;
`else
   localparam logic [2:0] S_RESET = S_IDLE;
`endif

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_csb;
   logic                  r_web;
   logic                  r_oeb;
   logic                  r_oe;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [CW-1:0]         r_cnt;
   logic                  w_init_done;
   logic                  w_accept;

`ifdef SRAM_CTRL_INIT_EN
   logic                  r_init_done;
   assign w_init_done = r_init_done;
`else
   assign w_init_done = 1'b1;
`endif

   assign w_accept  = req_valid && req_ready;
   assign init_done = w_init_done;
   assign rsp_valid = r_rvalid;
   assign rsp_rdata = r_rdata;
   assign sram_addr = r_addr;
   assign sram_csb  = r_csb;
   assign sram_web  = r_web;
   assign sram_oeb  = r_oeb;
   // Only the registered output-enable drives the shared bus; it is never set together with oeb=0.
   assign sram_data = r_oe ? r_wdata : {DATA_WIDTH{1'bz}};

   // Requests are taken only when the bus is free for a new SRAM cycle.
   always_comb begin
      req_ready = 1'b0;
      case (r_state)
         S_IDLE:  req_ready = w_init_done;
         S_WRITE: req_ready = 1'b1;
         default: req_ready = 1'b0;
      endcase
   end

   // Main sequencer: every SRAM pin and the response channel come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_RESET;
         r_addr   <= '0;
         r_csb    <= 1'b1;
         r_web    <= 1'b1;
         r_oeb    <= 1'b1;
         r_oe     <= 1'b0;
         r_wdata  <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_cnt    <= '0;
`ifdef SRAM_CTRL_INIT_EN
         r_init_done <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_WRITE: begin
               if (w_accept && req_we) begin
                  r_state <= S_WRITE;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_csb   <= 1'b0;
                  r_web   <= 1'b0;
                  r_oeb   <= 1'b1;
                  r_oe    <= 1'b1;
               end else if (w_accept) begin
                  r_state <= S_RD_ISSUE;
                  r_addr  <= req_addr;
                  r_csb   <= 1'b0;
                  r_web   <= 1'b1;
                  r_oeb   <= 1'b0;
                  r_oe    <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_csb   <= 1'b1;
                  r_web   <= 1'b1;
                  r_oeb   <= 1'b1;
                  r_oe    <= 1'b0;
               end
            end
            S_RD_ISSUE: begin
               // Macro samples the address on this edge; start the latency count.
               r_state <= S_RD_WAIT;
               r_cnt   <= '0;
            end
            S_RD_WAIT: begin
               if (r_cnt == CNT_LAST) begin
                  r_rdata  <= sram_data;
                  r_rvalid <= 1'b1;
                  r_csb    <= 1'b1;
                  r_oeb    <= 1'b1;
                  r_state  <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               // Bus stays idle here, giving the turnaround cycle before any write.
               if (rsp_ready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
`ifdef SRAM_CTRL_INIT_EN
            S_INIT: begin
               if (r_csb) begin
                  // First sweep cycle: present address 0 with zero data.
                  r_addr  <= '0;
                  r_wdata <= '0;
                  r_csb   <= 1'b0;
                  r_web   <= 1'b0;
                  r_oeb   <= 1'b1;
                  r_oe    <= 1'b1;
               end else if (r_addr == {ADDR_WIDTH{1'b1}}) begin
                  // The last word is written on this edge.
                  r_csb       <= 1'b1;
                  r_web       <= 1'b1;
                  r_oe        <= 1'b0;
                  r_init_done <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
               r_csb   <= 1'b1;
               r_web   <= 1'b1;
               r_oeb   <= 1'b1;
               r_oe    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl_initiator.sv
// tb/tb_sram_ctrl_initiator.sv - directed self-checking bench for sram_ctrl_initiator with a behavioural SRAM
module tb_sram_ctrl_initiator;
   localparam int DW = 2;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          init_done;
   logic [AW-1:0] sram_addr;
   logic          sram_csb;
   logic          sram_web;
   logic          sram_oeb;
   wire  [DW-1:0] sram_data;

   int n_chk = 0;
   int n_err = 0;

   sram_ctrl_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .init_done(init_done),
      .sram_addr(sram_addr), .sram_csb(sram_csb), .sram_web(sram_web),
      .sram_oeb(sram_oeb), .sram_data(sram_data)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM: writes on the edge, read data driven the cycle after sampling.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          m_drv = 1'b0;
   logic [DW-1:0] m_dout = '0;
   always @(posedge clk) begin
      if (!sram_csb && !sram_web) mem[sram_addr] <= sram_data;
      if (!sram_csb && sram_web && !sram_oeb) begin
         m_dout <= mem[sram_addr];
         m_drv  <= 1'b1;
      end else begin
         m_drv <= 1'b0;
      end
   end
   assign sram_data = m_drv ? m_dout : {DW{1'bz}};

   // Bus monitor: write strobes while reading or while the macro drives, and read->write gap.
   int  viol = 0;
   int  gap = 0;
   int  gap_at_write = -1;
   bit  seen_rd = 1'b0;
   bit  cnt_csb_en = 1'b0;
   int  csb_low = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (!sram_oeb && !sram_web) viol++;
         if (m_drv && !sram_web) viol++;
         if (!sram_oeb) begin
            seen_rd = 1'b1;
            gap = 0;
         end else if (seen_rd && !sram_web) begin
            gap_at_write = gap;
            seen_rd = 1'b0;
         end else if (seen_rd && sram_csb && sram_web) begin
            gap++;
         end
         if (cnt_csb_en && !sram_csb) csb_low++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int stalls);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      stalls    = 0;
      while (!req_ready && stalls < 300) begin
         @(posedge clk); #1;
         stalls++;
      end
      if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic get_rsp(input logic rdy, output logic [DW-1:0] d, output int edges);
      rsp_ready = rdy;
      edges = 0;
      while (!rsp_valid && edges < 50) begin
         @(posedge clk); #1;
         edges++;
      end
      if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
      d = rsp_rdata;
      if (rdy) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_init();
      int n = 0;
      while (!init_done && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("init_done", {31'd0, init_done}, 32'd1);
`ifdef SRAM_CTRL_INIT_EN
      check("init_len_ge128", {31'd0, (n >= 128)}, 32'd1);
`endif
   endtask

   initial begin
      logic [DW-1:0] d;
      int st, ed, tot;
      for (int i = 0; i < (1<<AW); i++) mem[i] = 2'b11;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_csb", {31'd0, sram_csb}, 32'd1);
      check("rst_web", {31'd0, sram_web}, 32'd1);
      check("rst_oeb", {31'd0, sram_oeb}, 32'd1);
      check("rst_addr", {25'd0, sram_addr}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {30'd0, rsp_rdata}, 32'd0);
`ifdef SRAM_CTRL_INIT_EN
      check("rst_init_done", {31'd0, init_done}, 32'd0);
`else
      check("rst_init_done", {31'd0, init_done}, 32'd1);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
`endif
      rst = 1'b0;
      wait_init();

`ifdef SRAM_CTRL_INIT_EN
      // Zero-fill sweep: top word reads back 0.
      send(1'b0, 7'h7F, 2'b00, st);
      get_rsp(1'b1, d, ed);
      check("t6_init_rd_7f", {30'd0, d}, 32'd0);
`endif

      // Test 1: single write then read.
      cnt_csb_en = 1'b1;
      send(1'b1, 7'h05, 2'b10, st);
      repeat (3) @(posedge clk);
      #1;
      cnt_csb_en = 1'b0;
      check("t1_csb_low_cycles", csb_low, 32'd1);
      send(1'b0, 7'h05, 2'b00, st);
      get_rsp(1'b1, d, ed);
      check("t1_rd_latency", ed, 32'd2);
      check("t1_rd_data", {30'd0, d}, 32'd2);
      check("t1_rsp_drop", {31'd0, rsp_valid}, 32'd0);

      // Test 2: full-depth back-to-back writes, then read everything back.
      tot = 0;
      for (int a = 0; a < 128; a++) begin
         send(1'b1, AW'(a), DW'(a), st);
         if (a > 0) tot += st;
      end
      check("t2_b2b_stalls", tot, 32'd0);
      for (int a = 0; a < 128; a++) begin
         send(1'b0, AW'(a), 2'b00, st);
         get_rsp(1'b1, d, ed);
         check($sformatf("t2_rd_%0h", a), {30'd0, d}, a & 3);
      end

      // Test 3: response back-pressure.
      send(1'b0, 7'h7E, 2'b00, st);
      get_rsp(1'b0, d, ed);
      for (int c = 0; c < 5; c++) begin
         check("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("t3_hold_data", {30'd0, rsp_rdata}, 32'd2);
         check("t3_req_ready", {31'd0, req_ready}, 32'd0);
         check("t3_csb", {31'd0, sram_csb}, 32'd1);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_released", {31'd0, rsp_valid}, 32'd0);
      check("t3_ready_back", {31'd0, req_ready}, 32'd1);

      // Test 4: read followed immediately by a write to the same word.
      send(1'b0, 7'h10, 2'b00, st);
      get_rsp(1'b1, d, ed);
      check("t4_rd_old", {30'd0, d}, 32'd0);
      send(1'b1, 7'h10, 2'b01, st);
      @(posedge clk); #1;
      check("t4_rw_gap", {31'd0, (gap_at_write >= 1)}, 32'd1);
      send(1'b0, 7'h10, 2'b00, st);
      get_rsp(1'b1, d, ed);
      check("t4_rd_new", {30'd0, d}, 32'd1);
      check("t4_bus_conflict", viol, 32'd0);

      // Test 5: reset while waiting for read data.
      send(1'b0, 7'h20, 2'b00, st);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("t5_csb", {31'd0, sram_csb}, 32'd1);
      check("t5_oeb", {31'd0, sram_oeb}, 32'd1);
      check("t5_web", {31'd0, sram_web}, 32'd1);
      check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_init();
      repeat (2) @(posedge clk);
      #1;
      check("t5_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
      send(1'b0, 7'h7E, 2'b00, st);
      get_rsp(1'b1, d, ed);
`ifdef SRAM_CTRL_INIT_EN
      check("t5_rd_after_rst", {30'd0, d}, 32'd0);
`else
      check("t5_rd_after_rst", {30'd0, d}, 32'd2);
`endif
      check("final_bus_conflict", viol, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
